// File: rtl/vga_frame_blitter_pkg.sv
// Shared definitions for the per-frame screen blitter: FSM encoding, screen ids,
// default geometry and fixed port widths of the VGA adapter.
package vga_frame_blitter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAW  = 2'd1,
        ST_FLUSH = 2'd2
    } blit_state_t;

    localparam int SCR_MENU  = 0;
    localparam int SCR_RED   = 1;
    localparam int SCR_GREEN = 2;
    localparam int SCR_SCORE = 3;

    localparam int DEF_H_RES = 320;
    localparam int DEF_V_RES = 240;

    localparam int ADDR_W = 17;
    localparam int X_W    = 9;
    localparam int Y_W    = 8;

    function automatic int scrWidth(input int numScreens);
        return (numScreens > 1) ? $clog2(numScreens) : 1;
    endfunction

endpackage

// File: rtl/vga_frame_blitter_if.sv
// Bus between the blitter, the screen ROMs and the VGA adapter pixel-write port.
interface vga_frame_blitter_if
    import vga_frame_blitter_pkg::*;
#(
    parameter int COLOR_W     = 3,
    parameter int NUM_SCREENS = 4
);
    // No valid/ready here: ROM reads are fixed-latency, and writeEn is a one-cycle
    // write strobe with no back-pressure; x/y/color are meaningful only while it is high.
    logic [ADDR_W-1:0]              oRomAddr;
    logic [NUM_SCREENS*COLOR_W-1:0] iRomData;
    logic [X_W-1:0]                 x;
    logic [Y_W-1:0]                 y;
    logic [COLOR_W-1:0]             color;
    logic                           writeEn;

    modport master (output oRomAddr, x, y, color, writeEn, input iRomData);
    modport slave  (input oRomAddr, x, y, color, writeEn, output iRomData);
endinterface

// File: rtl/vga_vsync_sync.sv
// Brings the asynchronous active-low V_SYNC into clk and emits a 1-cycle pulse on its fall.
module vga_vsync_sync (
    input  logic clk,
    input  logic iReset,
    input  logic V_SYNC,
    output logic vsFall
);
    // [0],[1] synchronise; [2] is the previous synchronised value for edge detection.
    logic [2:0] syncQ;

    always_ff @(posedge clk) begin
        if (iReset) begin
            syncQ <= 3'b111;
        end else begin
            syncQ <= {syncQ[1:0], V_SYNC};
        end
    end

    assign vsFall = syncQ[2] & ~syncQ[1];
endmodule

// File: rtl/vga_frame_blitter.sv
// Copies one full screen image from the selected ROM into the VGA adapter on every
// V_SYNC fall, one pixel per clk, with an optional solid cursor square overlaid.
module vga_frame_blitter
    import vga_frame_blitter_pkg::*;
#(
    parameter int H_RES       = DEF_H_RES,
    parameter int V_RES       = DEF_V_RES,
    parameter int COLOR_W     = 3,
    parameter int NUM_SCREENS = 4,
    parameter int ROM_LAT     = 1,
    parameter int CUR_SIZE    = 4,
    parameter logic [COLOR_W-1:0] CUR_COLOR = '1,
    localparam int SCR_W      = scrWidth(NUM_SCREENS)
) (
    input  logic                 clk,
    input  logic                 iReset,
    input  logic                 V_SYNC,
    input  logic                 keyPress,
    input  logic [1:0]           iGameMode,
    input  logic                 iCurEn,
    input  logic [X_W-1:0]       iMouseX,
    input  logic [Y_W-1:0]       iMouseY,
    vga_frame_blitter_if.master  bus,
    output logic [SCR_W-1:0]     oScreen,
    output logic                 oFrameDone,
    output logic                 oOverrun,
    output blit_state_t          oState
);
    logic vsFall;

    vga_vsync_sync uSync (.clk(clk), .iReset(iReset), .V_SYNC(V_SYNC), .vsFall(vsFall));

    blit_state_t       state, stateNext;
    logic [ADDR_W-1:0] addr;
    logic [X_W-1:0]    cx;
    logic [Y_W-1:0]    cy;
    logic [1:0]        flushCnt;
    logic              lastPix, frameStart, frameEnd;

    assign lastPix    = (cx == X_W'(H_RES - 1)) && (cy == Y_W'(V_RES - 1));
    assign frameStart = (state == ST_IDLE) && vsFall;

    always_comb begin
        stateNext = state;
        frameEnd  = 1'b0;
        case (state)
            ST_IDLE:  if (vsFall) stateNext = ST_DRAW;
            ST_DRAW:  if (lastPix) stateNext = ST_FLUSH;
            ST_FLUSH: if (flushCnt == 2'(ROM_LAT - 1)) begin
                stateNext = ST_IDLE;
                frameEnd  = 1'b1;
            end
            default:  stateNext = ST_IDLE;
        endcase
    end

    // Address walks raster order by +1; x/y are tracked alongside so no multiply is needed.
    always_ff @(posedge clk) begin
        if (iReset) begin
            state      <= ST_IDLE;
            addr       <= '0;
            cx         <= '0;
            cy         <= '0;
            flushCnt   <= '0;
            oFrameDone <= 1'b0;
        end else begin
            state      <= stateNext;
            oFrameDone <= frameEnd;
            if (frameStart || (state == ST_DRAW && lastPix)) begin
                addr     <= '0;
                cx       <= '0;
                cy       <= '0;
                flushCnt <= '0;
            end else if (state == ST_DRAW) begin
                addr <= addr + ADDR_W'(1);
                if (cx == X_W'(H_RES - 1)) begin
                    cx <= '0;
                    cy <= cy + Y_W'(1);
                end else begin
                    cx <= cx + X_W'(1);
                end
            end else if (state == ST_FLUSH) begin
                flushCnt <= flushCnt + 2'd1;
            end
        end
    end

    logic              keyPrev, keyRise, curEn;
    logic [SCR_W-1:0]  pend;
    logic [X_W-1:0]    curX;
    logic [Y_W-1:0]    curY;

    assign keyRise = keyPress & ~keyPrev;

    // Pending selection is free to move; oScreen and the cursor latch only at frame start.
    always_ff @(posedge clk) begin
        if (iReset) begin
            keyPrev  <= 1'b0;
            pend     <= SCR_W'(SCR_MENU);
            oScreen  <= SCR_W'(SCR_MENU);
            curEn    <= 1'b0;
            curX     <= '0;
            curY     <= '0;
            oOverrun <= 1'b0;
        end else begin
            keyPrev <= keyPress;
            if (iGameMode != 2'd0) begin
                pend <= (int'(iGameMode) >= NUM_SCREENS) ? SCR_W'(NUM_SCREENS - 1)
                                                         : SCR_W'(iGameMode);
            end else if (keyRise) begin
                pend <= (pend == SCR_W'(NUM_SCREENS - 1)) ? '0 : pend + SCR_W'(1);
            end
            if (frameStart) begin
                oScreen <= pend;
                curEn   <= iCurEn;
                curX    <= iMouseX;
                curY    <= iMouseY;
            end
            if (vsFall && state != ST_IDLE) oOverrun <= 1'b1;
        end
    end

    logic [ROM_LAT-1:0] vPipe;
    logic [X_W-1:0]     xPipe [ROM_LAT];
    logic [Y_W-1:0]     yPipe [ROM_LAT];

    always_ff @(posedge clk) begin
        if (iReset) begin
            vPipe <= '0;
            for (int i = 0; i < ROM_LAT; i++) begin
                xPipe[i] <= '0;
                yPipe[i] <= '0;
            end
        end else begin
            vPipe[0] <= (state == ST_DRAW);
            xPipe[0] <= cx;
            yPipe[0] <= cy;
            for (int i = 1; i < ROM_LAT; i++) begin
                vPipe[i] <= vPipe[i-1];
                xPipe[i] <= xPipe[i-1];
                yPipe[i] <= yPipe[i-1];
            end
        end
    end

    logic               wEn, inCur;
    logic [X_W-1:0]     pixX;
    logic [Y_W-1:0]     pixY;
    logic [COLOR_W-1:0] romPix;

    assign wEn    = vPipe[ROM_LAT-1];
    assign pixX   = xPipe[ROM_LAT-1];
    assign pixY   = yPipe[ROM_LAT-1];
    assign romPix = bus.iRomData[oScreen*COLOR_W +: COLOR_W];

    // One extra bit so a cursor near the right/bottom edge never wraps to column/row 0.
    assign inCur = curEn
        && ({1'b0, pixX} >= {1'b0, curX}) && ({1'b0, pixX} < {1'b0, curX} + (X_W+1)'(CUR_SIZE))
        && ({1'b0, pixY} >= {1'b0, curY}) && ({1'b0, pixY} < {1'b0, curY} + (Y_W+1)'(CUR_SIZE));

    assign bus.oRomAddr = addr;
    assign bus.writeEn  = wEn;
    assign bus.x        = pixX;
    assign bus.y        = pixY;
    assign bus.color    = !wEn ? '0 : (inCur ? CUR_COLOR : romPix);
    assign oState       = state;
endmodule

// File: tb/tb_vga_frame_blitter.sv
// Bench for vga_frame_blitter: an 8x4 screen drawn by two instances (ROM latency 1 and 3).
module tb_vga_frame_blitter;
    import vga_frame_blitter_pkg::*;

    localparam int HR = 8, VR = 4, CW = 3, NS = 4, NPIX = HR * VR;
    localparam int LAT_A = 1, LAT_B = 3;

    logic       clk = 1'b0, iReset = 1'b1, V_SYNC = 1'b1, keyPress = 1'b0, iCurEn = 1'b0;
    logic [1:0] iGameMode = 2'd0;
    logic [8:0] iMouseX = '0;
    logic [7:0] iMouseY = '0;
    logic [1:0] scrA, scrB;
    logic       doneA, doneB, ovA, ovB;
    blit_state_t stA, stB;

    int checks = 0, failures = 0;
    logic [19:0] exp_qa[$], exp_qb[$];

    vga_frame_blitter_if #(.COLOR_W(CW), .NUM_SCREENS(NS)) busA ();
    vga_frame_blitter_if #(.COLOR_W(CW), .NUM_SCREENS(NS)) busB ();

    vga_frame_blitter #(.H_RES(HR), .V_RES(VR), .COLOR_W(CW), .NUM_SCREENS(NS),
                        .ROM_LAT(LAT_A), .CUR_SIZE(4), .CUR_COLOR(3'b111)) dutA (
        .clk(clk), .iReset(iReset), .V_SYNC(V_SYNC), .keyPress(keyPress),
        .iGameMode(iGameMode), .iCurEn(iCurEn), .iMouseX(iMouseX), .iMouseY(iMouseY),
        .bus(busA), .oScreen(scrA), .oFrameDone(doneA), .oOverrun(ovA), .oState(stA));

    vga_frame_blitter #(.H_RES(HR), .V_RES(VR), .COLOR_W(CW), .NUM_SCREENS(NS),
                        .ROM_LAT(LAT_B), .CUR_SIZE(4), .CUR_COLOR(3'b111)) dutB (
        .clk(clk), .iReset(iReset), .V_SYNC(V_SYNC), .keyPress(keyPress),
        .iGameMode(iGameMode), .iCurEn(iCurEn), .iMouseX(iMouseX), .iMouseY(iMouseY),
        .bus(busB), .oScreen(scrB), .oFrameDone(doneB), .oOverrun(ovB), .oState(stB));

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    // ---------------- ROM models: screen k holds addr[2:0] ^ k ----------------
    function automatic logic [NS*CW-1:0] rom_word(input logic [16:0] a);
        logic [NS*CW-1:0] w;
        for (int k = 0; k < NS; k++) w[k*CW +: CW] = a[2:0] ^ 3'(k);
        return w;
    endfunction

    logic [16:0] addrPipeB [2];
    initial begin
        busA.iRomData = '0;
        busB.iRomData = '0;
    end
    always @(posedge clk) begin
        busA.iRomData <= rom_word(busA.oRomAddr);
        addrPipeB[0]  <= busB.oRomAddr;
        addrPipeB[1]  <= addrPipeB[0];
        busB.iRomData <= rom_word(addrPipeB[1]);
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every strobe pops one {y,x,color} expectation.
    always @(negedge clk) begin
        if (busA.writeEn) begin
            if (exp_qa.size() == 0) check("pixA_unexpected", 1, 0);
            else check("pixA", {busA.y, busA.x, busA.color}, exp_qa.pop_front());
        end
        if (busB.writeEn) begin
            if (exp_qb.size() == 0) check("pixB_unexpected", 1, 0);
            else check("pixB", {busB.y, busB.x, busB.color}, exp_qb.pop_front());
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_frame(input int scr, input logic en, input int mx, input int my);
        for (int i = 0; i < NPIX; i++) begin
            int px, py;
            logic [2:0] c;
            px = i % HR;
            py = i / HR;
            c  = 3'(i) ^ 3'(scr);
            if (en && px >= mx && px < mx + 4 && py >= my && py < my + 4) c = 3'b111;
            exp_qa.push_back({8'(py), 9'(px), c});
            exp_qb.push_back({8'(py), 9'(px), c});
        end
    endtask

    typedef struct {
        logic [1:0] gm;
        int         keys;
        int         keyStart;
        logic       curEn;
        int         mx;
        int         my;
        logic       overrun;
        int         expScr;
        logic       expOv;
    } frame_vec_t;

    // V_SYNC drops just after posedge P0: sync flops take P0+1,P0+2, the frame starts at P0+3,
    // so the first strobe follows edge P0+3+LAT, i.e. negedge number LAT+4 of the loop below.
    task automatic run_frame(input frame_vec_t v, input int idx);
        int firstA = 0, firstB = 0, lastA = 0, lastB = 0, cntA = 0, cntB = 0;
        int doneAt_A = 0, doneAt_B = 0, nDoneA = 0, nDoneB = 0;
        string t;
        t = $sformatf("f%0d_", idx);
        iGameMode = v.gm;
        iCurEn    = v.curEn;
        iMouseX   = 9'(v.mx);
        iMouseY   = 8'(v.my);
        repeat (2) @(negedge clk);
        push_frame(v.expScr, v.curEn, v.mx, v.my);
        @(posedge clk);
        #1 V_SYNC = 1'b0;
        for (int n = 1; n <= 48; n++) begin
            @(negedge clk);
            if (busA.writeEn) begin
                if (firstA == 0) begin
                    firstA = n;
                    check({t, "screenA"}, scrA, v.expScr);
                    check({t, "stateA_draw"}, stA, ST_DRAW);
                end
                lastA = n;
                cntA++;
            end
            if (busB.writeEn) begin
                if (firstB == 0) begin
                    firstB = n;
                    check({t, "screenB"}, scrB, v.expScr);
                end
                lastB = n;
                cntB++;
            end
            if (doneA) begin nDoneA++; doneAt_A = n; end
            if (doneB) begin nDoneB++; doneAt_B = n; end
            if (n == 5) V_SYNC = 1'b1;
            if (v.overrun && n == 14) V_SYNC = 1'b0;
            if (n == 18) V_SYNC = 1'b1;
            if (v.keys > 0 && n >= v.keyStart && n < v.keyStart + 2 * v.keys)
                keyPress = ((n - v.keyStart) % 2 == 0);
            if (n == 20) begin
                iMouseX = iMouseX + 9'd3;
                iCurEn  = ~iCurEn;
            end
        end
        check({t, "firstA"}, firstA, LAT_A + 4);
        check({t, "firstB"}, firstB, LAT_B + 4);
        check({t, "strobesA"}, {32'(cntA), 32'(lastA - firstA + 1)}, {32'(NPIX), 32'(NPIX)});
        check({t, "strobesB"}, {32'(cntB), 32'(lastB - firstB + 1)}, {32'(NPIX), 32'(NPIX)});
        check({t, "doneA"}, {32'(nDoneA), 32'(doneAt_A)}, {32'd1, 32'(firstA + NPIX)});
        check({t, "doneB"}, {32'(nDoneB), 32'(doneAt_B)}, {32'd1, 32'(firstB + NPIX)});
        check({t, "screen_heldA"}, scrA, v.expScr);
        check({t, "queues_empty"}, {32'(exp_qa.size()), 32'(exp_qb.size())}, 64'd0);
        check({t, "overrun"}, {ovA, ovB}, {v.expOv, v.expOv});
        check({t, "state_idle"}, {stA, stB}, {ST_IDLE, ST_IDLE});
    endtask

    // ---------------- test sequence ----------------
    frame_vec_t vecs [7];
    int cnt;
    logic hit;

    initial begin
        // gm keys kStart curEn mx my ovr expScr expOv
        vecs[0] = '{2'd0, 5, 8,  1'b0, 0, 0, 1'b0, 0, 1'b0}; // screen 0, ROM=addr; 5 rises mid-frame
        vecs[1] = '{2'd0, 2, 3,  1'b1, 6, 2, 1'b0, 1, 1'b0}; // 5 mod 4 = 1; first rise with vs_fall
        vecs[2] = '{2'd0, 1, 10, 1'b1, 0, 0, 1'b0, 3, 1'b0}; // wraps 3 -> 0 for the next frame
        vecs[3] = '{2'd2, 3, 8,  1'b1, 3, 1, 1'b0, 2, 1'b0}; // game mode overrides keys
        vecs[4] = '{2'd0, 1, 8,  1'b0, 2, 1, 1'b0, 2, 1'b0}; // cursor disabled
        vecs[5] = '{2'd0, 0, 8,  1'b1, 7, 3, 1'b1, 3, 1'b1}; // bottom-right cursor; overrun
        vecs[6] = '{2'd1, 0, 8,  1'b1, 5, 0, 1'b0, 1, 1'b1}; // overrun stays sticky

        repeat (3) @(negedge clk);
        check("reset_outA", {busA.writeEn, busA.x, busA.y, busA.color, busA.oRomAddr,
                             scrA, doneA, ovA, stA}, 64'd0);
        check("reset_outB", {busB.writeEn, busB.x, busB.y, busB.color, busB.oRomAddr,
                             scrB, doneB, ovB, stB}, 64'd0);
        iReset = 1'b0;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 7; i++) run_frame(vecs[i], i);

        // Reset at pixel 10 of a screen-1 frame, then a clean frame of screen 0.
        iGameMode = 2'd0;
        iCurEn    = 1'b0;
        repeat (2) @(negedge clk);
        push_frame(1, 1'b0, 0, 0);
        @(posedge clk);
        #1 V_SYNC = 1'b0;
        cnt = 0;
        hit = 1'b0;
        for (int n = 1; n <= 40 && !hit; n++) begin
            @(negedge clk);
            if (busA.writeEn) cnt++;
            if (n == 5) V_SYNC = 1'b1;
            if (cnt == 10) begin
                iReset = 1'b1;
                hit    = 1'b1;
            end
        end
        V_SYNC = 1'b1;
        check("rst_reached_pixel10", hit, 1'b1);
        @(negedge clk);
        check("rst_wen", {busA.writeEn, busB.writeEn}, 2'b00);
        check("rst_midA", {busA.writeEn, busA.x, busA.y, busA.color, busA.oRomAddr,
                           scrA, doneA, ovA, stA}, 64'd0);
        check("rst_midB", {busB.writeEn, busB.x, busB.y, busB.color, busB.oRomAddr,
                           scrB, doneB, ovB, stB}, 64'd0);
        exp_qa.delete();
        exp_qb.delete();
        @(negedge clk);
        iReset = 1'b0;
        @(negedge clk);
        check("rst_no_stale", {busA.writeEn, busB.writeEn}, 2'b00);
        run_frame('{2'd0, 0, 8, 1'b0, 0, 0, 1'b0, 0, 1'b0}, 7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
